program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; all state changes on this edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: prog_mode  in  1  level from pin; 1 = hold CPU and accept program bytes.
REQ-004 SHALL have ports: prog_strobe  in  1  asynchronous pin; each rising edge offers one byte.
REQ-005 SHALL have ports: prog_data  in  8  program byte; host holds it stable while prog_strobe = 1.
REQ-006 SHALL have ports: bus_out  out  8  value driven onto the shared 8-bit bus.
REQ-007 SHALL have ports: bus_oe  out  1  1 = bus_out owns the bus.
REQ-008 SHALL have ports: n_load_addr  out  1  active-low MAR address load.
REQ-009 SHALL have ports: n_load_data  out  1  active-low MAR data load.
REQ-010 SHALL have ports: ram_we_n  out  1  active-low RAM write.
REQ-011 SHALL have ports: cpu_rst_n  out  1  active-low reset to CPU core and control block.
REQ-012 SHALL have ports: ready  out  1  1 = loader waiting for the next strobe.
REQ-013 SHALL have ports: done  out  1  1 = all 16 RAM bytes written.
REQ-014 SHALL have ports: load_addr  out  4  next RAM address to be written.

Function
REQ-015 SHALL pass prog_strobe through a 2-flop synchronizer, then a rising-edge detector; prog_mode SHALL also pass through a 2-flop synchronizer.
REQ-016 SHALL implement states IDLE, WAIT_STB, LOAD_ADDR, LOAD_DATA, WRITE, FULL, RUN.
REQ-017 From IDLE: next state SHALL be WAIT_STB when synced prog_mode = 1, RUN otherwise.
REQ-018 WAIT_STB: ready = 1; on a detected edge SHALL capture prog_data into a hold register and enter LOAD_ADDR; with synced prog_mode = 0 and no edge SHALL enter RUN.
REQ-019 LOAD_ADDR (1 cycle): bus_oe = 1, bus_out = {4'b0, load_addr}, n_load_addr = 0.
REQ-020 LOAD_DATA (1 cycle): bus_oe = 1, bus_out = hold register, n_load_data = 0.
REQ-021 WRITE (1 cycle): ram_we_n = 0, bus_oe = 0, load_addr incremented on exit.
REQ-022 WRITE exit SHALL go to FULL if load_addr was 15, else to WAIT_STB; load_addr SHALL wrap 15 -> 0 on that exit.
REQ-023 FULL: done = 1, strobes ignored; SHALL enter RUN when synced prog_mode = 0.
REQ-024 RUN: cpu_rst_n = 1, bus_oe = 0; on synced prog_mode = 1 SHALL clear load_addr and done and enter WAIT_STB.
REQ-025 cpu_rst_n SHALL be 0 in every state except RUN.
REQ-026 Only one of n_load_addr, n_load_data, ram_we_n SHALL be low in any cycle, and bus_oe SHALL be 0 whenever cpu_rst_n = 1.
REQ-027 prog_mode falling during LOAD_ADDR/LOAD_DATA/WRITE SHALL NOT abort; the current byte completes, then REQ-018 applies.
REQ-028 Strobe edges arriving outside WAIT_STB SHALL be dropped, not queued.
REQ-029 Latency: strobe first sampled high at edge N -> LOAD_ADDR entered at edge N+2, ram_we_n low between edges N+4 and N+5, ready = 1 again after edge N+5.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, load_addr 0, hold register 0, synchronizer flops 0, bus_oe 0, bus_out 0, n_load_addr/n_load_data/ram_we_n 1, cpu_rst_n 0, ready 0, done 0.
REQ-031 Reset asserted mid-write SHALL deassert ram_we_n asynchronously; no partial write retried.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the loader state enum, RAM_DEPTH = 16, ADDR_W = 4, DATA_W = 8.
REQ-033 Synchronizer plus edge detector SHALL be a sub-module named input_synchronizer, instantiated once for prog_strobe (edge output used) and once for prog_mode (level output used).
REQ-034 The top SHALL mux bus_out onto the bus by bus_oe and AND ram_we_n into the RAM write enable.

Verification
REQ-035 Reset with prog_mode = 1, send bytes 0x1A, 0x2B -> RAM[0] = 0x1A, RAM[1] = 0x2B, load_addr = 2, cpu_rst_n = 0.
REQ-036 Send 16 bytes 0x00..0x0F -> done = 1 after 16th WRITE; 17th strobe leaves RAM[0] = 0x00; prog_mode = 0 -> cpu_rst_n = 1.
REQ-037 Strobe at edge N -> n_load_addr low in cycle N+2..N+3, ram_we_n low in N+4..N+5 exactly.
REQ-038 Drop prog_mode during LOAD_DATA of byte 0x55 at address 3 -> RAM[3] = 0x55, then RUN.
REQ-039 Assert rst_n low during WRITE -> ram_we_n = 1 and cpu_rst_n = 0 before the next clock edge; state IDLE.
REQ-040 Reassert prog_mode in RUN -> cpu_rst_n = 0 within 3 cycles, load_addr = 0, next byte lands at RAM[0].

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: RAM geometry and loader FSM states.
package cpu_pkg;
  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_STB,
    ST_LOAD_ADDR,
    ST_LOAD_DATA,
    ST_WRITE,
    ST_FULL,
    ST_RUN
  } loader_state_e;
endpackage

// File: rtl/program_loader_if.sv
// Shared-bus side of the program loader: bus drive, MAR loads and RAM write strobe.
interface program_loader_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              n_load_addr;
  logic              n_load_data;
  logic              ram_we_n;

  modport master (output bus_out, bus_oe, n_load_addr, n_load_data, ram_we_n);
  modport slave  (input  bus_out, bus_oe, n_load_addr, n_load_data, ram_we_n);
endinterface

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge detector.
module input_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
endmodule

// File: rtl/program_loader.sv
// Loads 16 program bytes from a strobed host port into RAM through the MAR while
// holding the CPU in reset; releases the CPU when program mode drops.
module program_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              prog_strobe,
  input  logic [DATA_W-1:0] prog_data,
  program_loader_if.master  bus_if,
  output logic              cpu_rst_n,
  output logic              ready,
  output logic              done,
  output logic [ADDR_W-1:0] load_addr
);
  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;

  logic              stb_rise, mode_sync, stb_level_unused, mode_rise_unused;
  logic [DATA_W-1:0] bus_val;
  logic              bus_oe_c, we_n_c;

  input_synchronizer u_sync_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (prog_strobe),
    .level_o (stb_level_unused),
    .rise_o  (stb_rise)
  );

  input_synchronizer u_sync_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (prog_mode),
    .level_o (mode_sync),
    .rise_o  (mode_rise_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_addr_q <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    hold_d      = hold_q;
    done_d      = done_q;
    bus_oe_c    = 1'b0;
    bus_val     = '0;
    we_n_c      = 1'b1;
    cpu_rst_n   = 1'b0;
    ready       = 1'b0;
    bus_if.n_load_addr = 1'b1;
    bus_if.n_load_data = 1'b1;

    unique case (state_q)
      ST_IDLE: state_d = mode_sync ? ST_WAIT_STB : ST_RUN;
      ST_WAIT_STB: begin
        ready = 1'b1;
        if (stb_rise) begin
          hold_d  = prog_data;
          state_d = ST_LOAD_ADDR;
        end else if (!mode_sync) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD_ADDR: begin
        bus_oe_c           = 1'b1;
        bus_val            = {{(DATA_W-ADDR_W){1'b0}}, load_addr_q};
        bus_if.n_load_addr = 1'b0;
        state_d            = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        bus_oe_c           = 1'b1;
        bus_val            = hold_q;
        bus_if.n_load_data = 1'b0;
        state_d            = ST_WRITE;
      end
      ST_WRITE: begin
        we_n_c      = 1'b0;
        load_addr_d = load_addr_q + ADDR_W'(1);
        if (load_addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_WAIT_STB;
        end
      end
      ST_FULL: if (!mode_sync) state_d = ST_RUN;
      ST_RUN: begin
        cpu_rst_n = 1'b1;
        if (mode_sync) begin
          load_addr_d = '0;
          done_d      = 1'b0;
          state_d     = ST_WAIT_STB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the write strobe directly so a write in flight is cut off
  // without waiting for the state register to settle.
  assign bus_if.ram_we_n = we_n_c | ~rst_n;
  assign bus_if.bus_oe   = bus_oe_c;
  assign bus_if.bus_out  = bus_oe_c ? bus_val : '0;
  assign done            = done_q;
  assign load_addr       = load_addr_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a MAR/RAM model on the shared bus.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_mode;
  logic       prog_strobe;
  logic [7:0] prog_data;
  logic       cpu_rst_n, ready, done;
  logic [3:0] load_addr;

  program_loader_if bif();

  program_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_mode   (prog_mode),
    .prog_strobe (prog_strobe),
    .prog_data   (prog_data),
    .bus_if      (bif),
    .cpu_rst_n   (cpu_rst_n),
    .ready       (ready),
    .done        (done),
    .load_addr   (load_addr)
  );

  always #5 clk = ~clk;

  // MAR and RAM as the rest of the machine would see them, sampled mid-cycle.
  logic [3:0] mar_addr;
  logic [7:0] mar_data;
  logic [7:0] ram [16];

  always @(negedge clk) begin
    if (!bif.n_load_addr) mar_addr = bif.bus_out[3:0];
    if (!bif.n_load_data) mar_data = bif.bus_out;
    if (!bif.ram_we_n)    ram[mar_addr] = mar_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    prog_data   = d;
    prog_strobe = 1'b1;
    repeat (3) @(negedge clk);
    prog_strobe = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    prog_strobe = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_addr;
    logic       exp_done;
  } byte_vec_t;

  typedef struct {
    logic       nla;
    logic       nld;
    logic       we_n;
    logic       oe;
    logic       rdy;
    logic [7:0] bus;
  } cyc_vec_t;

  byte_vec_t fill_tbl [16];
  cyc_vec_t  cyc_tbl  [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      fill_tbl[i].data     = 8'(i);
      fill_tbl[i].exp_addr = 4'((i + 1) % 16);
      fill_tbl[i].exp_done = (i == 15);
    end
    // strobe transaction at address 2 with byte 0x3C, one row per cycle after edge N+k
    cyc_tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    cyc_tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    cyc_tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02};
    cyc_tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C};
    cyc_tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    cyc_tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 16; i++) ram[i] = 8'hEE;

    rst_n       = 1'b0;
    prog_mode   = 1'b1;
    prog_strobe = 1'b0;
    prog_data   = 8'h00;
    #2;
    chk("rst_bus_oe",    32'(bif.bus_oe), 32'd0);
    chk("rst_bus_out",   32'(bif.bus_out), 32'd0);
    chk("rst_nla",       32'(bif.n_load_addr), 32'd1);
    chk("rst_nld",       32'(bif.n_load_data), 32'd1);
    chk("rst_we_n",      32'(bif.ram_we_n), 32'd1);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_ready",     32'(ready), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_load_addr", 32'(load_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("boot_ready",     32'(ready), 32'd1);
    chk("boot_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

    // two bytes land at consecutive addresses
    send_byte(8'h1A);
    send_byte(8'h2B);
    chk("two_ram0",      32'(ram[0]), 32'h1A);
    chk("two_ram1",      32'(ram[1]), 32'h2B);
    chk("two_load_addr", 32'(load_addr), 32'd2);
    chk("two_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

    // cycle-exact latency from first strobe sample
    @(negedge clk);
    prog_data   = 8'h3C;
    prog_strobe = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat%0d_nla", k),  32'(bif.n_load_addr), 32'(cyc_tbl[k].nla));
      chk($sformatf("lat%0d_nld", k),  32'(bif.n_load_data), 32'(cyc_tbl[k].nld));
      chk($sformatf("lat%0d_we_n", k), 32'(bif.ram_we_n), 32'(cyc_tbl[k].we_n));
      chk($sformatf("lat%0d_oe", k),   32'(bif.bus_oe), 32'(cyc_tbl[k].oe));
      chk($sformatf("lat%0d_rdy", k),  32'(ready), 32'(cyc_tbl[k].rdy));
      chk($sformatf("lat%0d_bus", k),  32'(bif.bus_out), 32'(cyc_tbl[k].bus));
      chk($sformatf("lat%0d_cpu", k),  32'(cpu_rst_n), 32'd0);
      if (k == 2) prog_strobe = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("lat_ram2",      32'(ram[2]), 32'h3C);
    chk("lat_load_addr", 32'(load_addr), 32'd3);

    // prog_mode drops mid-byte: byte still completes, then CPU runs
    @(negedge clk);
    prog_data   = 8'h55;
    prog_strobe = 1'b1;
    repeat (4) @(negedge clk);
    chk("drop_in_load_data", 32'(bif.n_load_data), 32'd0);
    prog_mode   = 1'b0;
    prog_strobe = 1'b0;
    repeat (6) @(negedge clk);
    chk("drop_ram3",      32'(ram[3]), 32'h55);
    chk("drop_load_addr", 32'(load_addr), 32'd4);
    chk("drop_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("drop_bus_oe",    32'(bif.bus_oe), 32'd0);

    // re-enter program mode from RUN
    prog_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("reent_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("reent_load_addr", 32'(load_addr), 32'd0);
    chk("reent_ready",     32'(ready), 32'd1);
    send_byte(8'h77);
    chk("reent_ram0",   32'(ram[0]), 32'h77);
    chk("reent_addr1",  32'(load_addr), 32'd1);

    // full 16-byte fill from a fresh reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(fill_tbl[i].data);
      chk($sformatf("fill%0d_ram", i),  32'(ram[i]), 32'(fill_tbl[i].data));
      chk($sformatf("fill%0d_addr", i), 32'(load_addr), 32'(fill_tbl[i].exp_addr));
      chk($sformatf("fill%0d_done", i), 32'(done), 32'(fill_tbl[i].exp_done));
    end
    chk("full_ready", 32'(ready), 32'd0);
    send_byte(8'hAA);
    chk("full_ram0_kept", 32'(ram[0]), 32'h00);
    chk("full_addr_kept", 32'(load_addr), 32'd0);
    chk("full_done_kept", 32'(done), 32'd1);
    prog_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("full_run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("full_run_bus_oe",    32'(bif.bus_oe), 32'd0);

    // reset lands in the middle of a write
    prog_mode = 1'b1;
    repeat (4) @(negedge clk);
    chk("mw_cleared_done", 32'(done), 32'd0);
    @(negedge clk);
    prog_data   = 8'h99;
    prog_strobe = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mw_we_low", 32'(bif.ram_we_n), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mw_we_n",      32'(bif.ram_we_n), 32'd1);
    chk("mw_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("mw_ready",     32'(ready), 32'd0);
    chk("mw_bus_oe",    32'(bif.bus_oe), 32'd0);
    chk("mw_load_addr", 32'(load_addr), 32'd0);
    prog_strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk("mw_no_write", 32'(ram[0]), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
